ipic_lite_mux_master: RTL

Parametrised N-channel front end for the AXI master-lite IPIC port. Arbitrates single-beat read/write requests from NUM_CH user blocks (TDMA control, descriptor processor, future clients) with round-robin fairness. Runs one IPIC transaction at a time and returns read data and error status to the issuing channel. Adds a transaction watchdog and byte-enable passthrough.

---
 rtl/ipic_lite_mux_master_if.sv | 43 ++++
 rtl/ipic_lite_mux_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ipic_lite_mux_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ipic_lite_mux_master_if
// Brief    : AXI master-lite IPIC command/status bundle with master/slave views
// Revision : 1.0
// ============================================================================
interface ipic_lite_mux_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    ip2bus_mstrd_req;
  logic                    ip2bus_mstwr_req;
  logic [ADDR_WIDTH-1:0]   ip2bus_mst_addr;
  logic [DATA_WIDTH/8-1:0] ip2bus_mst_be;
  logic                    ip2bus_mst_lock;
  logic                    ip2bus_mst_reset;
  logic [DATA_WIDTH-1:0]   ip2bus_mstwr_d;
  logic                    bus2ip_mst_cmdack;
  logic                    bus2ip_mst_cmplt;
  logic                    bus2ip_mst_error;
  logic                    bus2ip_mst_rearbitrate;
  logic                    bus2ip_mst_cmd_timeout;
  logic [DATA_WIDTH-1:0]   bus2ip_mstrd_d;
  logic                    bus2ip_mstrd_src_rdy_n;
  logic                    bus2ip_mstwr_dst_rdy_n;

  modport master (
    output ip2bus_mstrd_req, ip2bus_mstwr_req, ip2bus_mst_addr, ip2bus_mst_be,
           ip2bus_mst_lock, ip2bus_mst_reset, ip2bus_mstwr_d,
    input  bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error,
           bus2ip_mst_rearbitrate, bus2ip_mst_cmd_timeout, bus2ip_mstrd_d,
           bus2ip_mstrd_src_rdy_n, bus2ip_mstwr_dst_rdy_n
  );

  modport slave (
    input  ip2bus_mstrd_req, ip2bus_mstwr_req, ip2bus_mst_addr, ip2bus_mst_be,
           ip2bus_mst_lock, ip2bus_mst_reset, ip2bus_mstwr_d,
    output bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error,
           bus2ip_mst_rearbitrate, bus2ip_mst_cmd_timeout, bus2ip_mstrd_d,
           bus2ip_mstrd_src_rdy_n, bus2ip_mstwr_dst_rdy_n
  );
endinterface
`default_nettype wire

// File: rtl/ipic_lite_mux_master.sv
`default_nettype none
// ============================================================================
// Module   : ipic_lite_mux_master
// Brief    : Round-robin N-channel front end for the IPIC master-lite port,
//            one transaction in flight, with watchdog abort.
//            Optional macro IPIC_ERR_CNT_EN adds a saturating err_cnt output.
// Revision : 1.0
// ============================================================================
module ipic_lite_mux_master #(
  parameter int NUM_CH         = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CH-1:0]                ch_req,
  input  logic [NUM_CH-1:0]                ch_wr,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]     ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     ch_wdata,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0]   ch_be,
  output logic [NUM_CH-1:0]                ch_done,
  output logic                             ch_err,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             busy,
  ipic_lite_mux_master_if.master           ipic
`ifdef IPIC_ERR_CNT_EN
  ,
  output logic [15:0]                      err_cnt
`endif
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  logic [2:0]            r_state;
  logic [CH_W-1:0]       r_grant;
  logic [CH_W-1:0]       r_ptr;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BE_W-1:0]       r_be;
  logic                  r_rd_req;
  logic                  r_wr_req;
  logic                  r_rearb;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_hi_found;
  logic [CH_W-1:0]       w_hi;
  logic [CH_W-1:0]       w_lo;
  logic [CH_W-1:0]       w_sel;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [BE_W-1:0]       w_sel_be;
  logic                  w_grant_now;
  logic                  w_active;
  logic                  w_req_on;
  logic                  w_timeout;
  logic                  w_unused_wr_rdy;

  // Lowest requester at/after the pointer wins; otherwise the lowest overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_req[i]) begin
        w_lo = CH_W'(i);
        if (CH_W'(i) >= r_ptr) begin
          w_hi       = CH_W'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_sel = w_hi_found ? w_hi : w_lo;
  end

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel == CH_W'(i)) begin
        w_sel_wr    = ch_wr[i];
        w_sel_addr  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_be    = ch_be[i*BE_W +: BE_W];
      end
    end
  end

  assign w_grant_now     = (r_state == S_IDLE) && (|ch_req);
  assign w_active        = (r_state == S_CMD) || (r_state == S_WAIT);
  assign w_req_on        = r_rd_req || r_wr_req;
  assign w_unused_wr_rdy = ipic.bus2ip_mstwr_dst_rdy_n;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd_on
      logic [WD_W-1:0] r_wd;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_wd <= '0;
        else if (w_grant_now) r_wd <= '0;
        else if (w_active)    r_wd <= r_wd + WD_W'(1);
      end
      assign w_timeout = w_active && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_wd_off
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_ptr    <= '0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '1;
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
      r_rearb  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_active && (ipic.bus2ip_mst_error || ipic.bus2ip_mst_cmd_timeout))
        r_err <= 1'b1;
      if (w_active && !r_wr && !ipic.bus2ip_mstrd_src_rdy_n)
        r_rdata <= ipic.bus2ip_mstrd_d;

      case (r_state)
        S_IDLE: begin
          if (|ch_req) begin
            r_state  <= S_CMD;
            r_grant  <= w_sel;
            r_wr     <= w_sel_wr;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_be     <= w_sel_be;
            r_rd_req <= ~w_sel_wr;
            r_wr_req <= w_sel_wr;
            r_rearb  <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
          end
        end
        S_CMD: begin
          // A completion in the same cycle as the watchdog limit still wins.
          if (w_req_on && ipic.bus2ip_mst_cmdack && ipic.bus2ip_mst_cmplt) begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_state  <= S_RESP;
          end else if (w_timeout) begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_state  <= S_ABORT;
          end else if (w_req_on && ipic.bus2ip_mst_cmdack) begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_state  <= S_WAIT;
          end else if (r_rearb) begin
            r_rd_req <= ~r_wr;
            r_wr_req <= r_wr;
            r_rearb  <= 1'b0;
          end else if (w_req_on && ipic.bus2ip_mst_rearbitrate) begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_rearb  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (ipic.bus2ip_mst_cmplt) r_state <= S_RESP;
          else if (w_timeout)        r_state <= S_ABORT;
        end
        S_ABORT: begin
          r_err   <= 1'b1;
          r_rdata <= '0;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_ptr   <= (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + CH_W'(1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ch_done = '0;
    for (int i = 0; i < NUM_CH; i++)
      ch_done[i] = (r_state == S_RESP) && (r_grant == CH_W'(i));
  end

  assign ch_err  = (r_state == S_RESP) && r_err;
  assign rd_data = r_rdata;
  assign busy    = (r_state != S_IDLE);

  assign ipic.ip2bus_mstrd_req = r_rd_req;
  assign ipic.ip2bus_mstwr_req = r_wr_req;
  assign ipic.ip2bus_mst_addr  = r_addr;
  assign ipic.ip2bus_mst_be    = r_be;
  assign ipic.ip2bus_mst_lock  = 1'b0;
  assign ipic.ip2bus_mst_reset = (r_state == S_ABORT);
  assign ipic.ip2bus_mstwr_d   = r_wdata;

`ifdef IPIC_ERR_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_cnt <= '0;
    else if ((r_state == S_RESP) && r_err && (err_cnt != 16'hFFFF))
      err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule
`default_nettype wire
